// File: rtl/qtcore_scan_sequencer.sv
// Host-side sequencer for the qtcore_a1 scan chain and run enable: byte-wide chain swap
// (write bytes shifted in MSB-first, previous contents captured as read bytes) and bounded runs.
module qtcore_scan_sequencer #(
  parameter int unsigned CHAIN_LEN = 168,
  parameter int unsigned RUN_W     = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_op_in,
  input  logic [RUN_W-1:0] cmd_arg_in,
  input  logic             wr_valid_in,
  output logic             wr_ready_out,
  input  logic [7:0]       wr_data_in,
  output logic             rd_valid_out,
  input  logic             rd_ready_in,
  output logic [7:0]       rd_data_out,
  output logic             scan_enable_out,
  output logic             scan_in_out,
  input  logic             scan_out_in,
  output logic             proc_en_out,
  input  logic             halt_in,
  output logic             done_out,
  output logic             halted_out,
  output logic             err_out
);

  localparam int unsigned NumBytes = CHAIN_LEN / 8;
  localparam int unsigned ByteW    = $clog2(NumBytes + 1);

  if ((CHAIN_LEN % 8) != 0 || CHAIN_LEN == 0) begin : g_len_check
    $error("CHAIN_LEN must be a nonzero multiple of 8");
  end

  typedef enum logic [2:0] {StIdle, StWaitByte, StShift, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             rd_pending;

  // A byte being consumed this cycle is not pending: the next shift can start right after.
  assign rd_pending = rd_valid_q & ~rd_ready_in;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    run_cnt_d  = run_cnt_q;
    rd_valid_d = rd_pending;
    halted_d   = halted_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_in) begin
          halted_d = 1'b0;
          err_d    = 1'b0;
          unique case (cmd_op_in)
            2'b00: begin
              state_d    = StWaitByte;
              byte_cnt_d = ByteW'(NumBytes);
            end
            2'b01: begin
              if (cmd_arg_in != '0) begin
                state_d   = StRun;
                run_cnt_d = cmd_arg_in;
              end else begin
                state_d = StDone;
              end
            end
            default: begin
              state_d = StDone;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StWaitByte: begin
        if (wr_valid_in && !rd_pending) begin
          tx_d      = wr_data_in;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        tx_d      = {tx_q[6:0], 1'b0};
        rx_d      = {rx_q[6:0], scan_out_in};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rd_data_d  = {rx_q[6:0], scan_out_in};
          rd_valid_d = 1'b1;
          byte_cnt_d = byte_cnt_q - ByteW'(1);
          state_d    = (byte_cnt_q == ByteW'(1)) ? StDone : StWaitByte;
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q - RUN_W'(1);
        if (halt_in) begin
          halted_d = 1'b1;
          state_d  = StDone;
        end else if (run_cnt_q == RUN_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      run_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      run_cnt_q  <= run_cnt_d;
      rd_valid_q <= rd_valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  // Core-facing pins decode only registered state so they never see a host input.
  assign cmd_ready_out   = (state_q == StIdle);
  assign wr_ready_out    = (state_q == StWaitByte) && !rd_pending;
  assign scan_enable_out = (state_q == StShift);
  assign scan_in_out     = (state_q == StShift) && tx_q[7];
  assign proc_en_out     = (state_q == StRun);
  assign done_out        = (state_q == StDone);
  assign rd_valid_out    = rd_valid_q;
  assign rd_data_out     = rd_data_q;
  assign halted_out      = halted_q;
  assign err_out         = err_q;

endmodule
